comb_glitch_filter: RTL and testbench

//  Downstream stage for the gate-delay combinational circuits: samples their asynchronous,

---
 rtl/comb_glitch_filter_pkg.sv | 21 ++
 rtl/comb_glitch_filter_defs.vh | 12 +
 rtl/comb_glitch_filter_sync_chain.sv | 25 ++
 rtl/comb_glitch_filter.sv | 144 ++++++++++++++
 tb/tb_comb_glitch_filter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/comb_glitch_filter_pkg.sv
// Package for comb_glitch_filter: FSM state type and default parameters.
// The values come from the shared defs include.
package comb_glitch_filter_pkg;

`include "comb_glitch_filter_defs.vh"

    typedef enum logic {
        S_STABLE = `CGF_S_STABLE,
        S_QUAL   = `CGF_S_QUAL
    } state_e;

    localparam int DEF_SYNC_STAGES   = `CGF_SYNC_STAGES;
    localparam int DEF_STABLE_CYCLES = `CGF_STABLE_CYCLES;
    localparam int DEF_CNT_W         = `CGF_CNT_W;

    // Clean-step latency in clk edges from the first edge that sees new din.
    function automatic int step_latency(input int sync_stages, input int stable_cycles);
        return sync_stages + stable_cycles;
    endfunction

endpackage

// File: rtl/comb_glitch_filter_defs.vh
// Shared encodings and default parameter values for comb_glitch_filter.
// Pulled in by comb_glitch_filter_pkg.
`ifndef COMB_GLITCH_FILTER_DEFS_VH
`define COMB_GLITCH_FILTER_DEFS_VH

`define CGF_S_STABLE      1'b0
`define CGF_S_QUAL        1'b1
`define CGF_SYNC_STAGES   2
`define CGF_STABLE_CYCLES 4
`define CGF_CNT_W         8

`endif

// File: rtl/comb_glitch_filter_sync_chain.sv
// sync_chain: SYNC_STAGES-deep reset-to-0 synchronizer bringing the
// asynchronous din into the clk domain.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/comb_glitch_filter.sv
// comb_glitch_filter: synchronizes a hazard-prone level, qualifies it for STABLE_CYCLES
// samples, emits edge pulses and counts rejected glitches. Optional GLITCH_FILTER_IRQ_EN adds glitch_irq.
module comb_glitch_filter
    import comb_glitch_filter_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             dout,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] glitch_cnt
`ifdef GLITCH_FILTER_IRQ_EN
    ,
    output logic             glitch_irq
`endif
);

    localparam int QW = $clog2(STABLE_CYCLES + 1);
    localparam logic [QW-1:0] QUAL_LAST = QW'(STABLE_CYCLES);

    logic             synced;
    state_e           state_q, state_d;
    logic [QW-1:0]    qual_q, qual_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             glitch_inc;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (din),
        .q_o   (synced)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        qual_d     = qual_q;
        dout_d     = dout_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_inc = 1'b0;
        unique case (state_q)
            S_STABLE: begin
                if (synced != dout_q) begin
                    if (STABLE_CYCLES == 1) begin
                        dout_d = synced;
                        rise_d = synced;
                        fall_d = ~synced;
                    end else begin
                        state_d = S_QUAL;
                        qual_d  = QW'(1);
                    end
                end
            end
            S_QUAL: begin
                if (synced != dout_q) begin
                    if (qual_q + QW'(1) == QUAL_LAST) begin
                        dout_d  = synced;
                        rise_d  = synced;
                        fall_d  = ~synced;
                        qual_d  = '0;
                        state_d = S_STABLE;
                    end else begin
                        qual_d = qual_q + QW'(1);
                    end
                end else begin
                    // Level fell back before qualifying: count it as a rejected glitch.
                    qual_d     = '0;
                    state_d    = S_STABLE;
                    glitch_inc = 1'b1;
                end
            end
            default: state_d = S_STABLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (glitch_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_STABLE;
            qual_q  <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            qual_q  <= qual_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout       = dout_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = (state_q == S_QUAL);
    assign glitch_cnt = cnt_q;

`ifdef GLITCH_FILTER_IRQ_EN
    logic irq_q, irq_d;

    // Sticky on every abort, even when the counter is already saturated.
    always_comb begin
        irq_d = irq_q;
        if (clr_cnt) begin
            irq_d = 1'b0;
        end else if (glitch_inc) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign glitch_irq = irq_q;
`endif

endmodule

// File: tb/tb_comb_glitch_filter.sv
// Self-checking bench for comb_glitch_filter: cycle-vector table plus hand sequences
// for saturation (CNT_W=2 instance) and mid-qualification reset.
module tb_comb_glitch_filter;
    import comb_glitch_filter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din_a = 1'b0;
    logic clr_a = 1'b0;
    logic din_b = 1'b0;
    logic dout_a, rise_a, fall_a, busy_a;
    logic dout_b, rise_b, fall_b, busy_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
`ifdef GLITCH_FILTER_IRQ_EN
    logic irq_a, irq_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    comb_glitch_filter dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din_a),
        .clr_cnt    (clr_a),
        .dout       (dout_a),
        .rise_pulse (rise_a),
        .fall_pulse (fall_a),
        .busy       (busy_a),
        .glitch_cnt (cnt_a)
`ifdef GLITCH_FILTER_IRQ_EN
        ,
        .glitch_irq (irq_a)
`endif
    );

    comb_glitch_filter #(.CNT_W(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din_b),
        .clr_cnt    (1'b0),
        .dout       (dout_b),
        .rise_pulse (rise_b),
        .fall_pulse (fall_b),
        .busy       (busy_b),
        .glitch_cnt (cnt_b)
`ifdef GLITCH_FILTER_IRQ_EN
        ,
        .glitch_irq (irq_b)
`endif
    );

    typedef struct {
        logic       din;
        logic       clr;
        logic       dout;
        logic       rise;
        logic       fall;
        logic       busy;
        logic [7:0] cnt;
        logic       irq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic d, input logic c, input logic o, input logic r,
                       input logic f, input logic b, input logic [7:0] n, input logic i);
        vec_t v;
        v.din = d; v.clr = c; v.dout = o; v.rise = r; v.fall = f; v.busy = b; v.cnt = n; v.irq = i;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int glitches;
        logic [1:0] exp_b [5];
        lat = step_latency(DEF_SYNC_STAGES, DEF_STABLE_CYCLES);
        exp_b = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Test 2: clean rise then fall; test 3: 2-cycle glitch; test 5: clr vs abort.
        for (int k = 1; k <= 10; k++)
            add(1, 0, k >= lat, k == lat, 0, (k >= 3) && (k < lat), 8'd0, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 0, k < lat, 0, k == lat, (k >= 3) && (k < lat), 8'd0, 0);
        add(1, 0, 0, 0, 0, 0, 8'd0, 0);
        add(1, 0, 0, 0, 0, 0, 8'd0, 0);
        add(0, 0, 0, 0, 0, 1, 8'd0, 0);
        add(0, 0, 0, 0, 0, 1, 8'd0, 0);
        add(0, 0, 0, 0, 0, 0, 8'd1, 1);
        add(0, 0, 0, 0, 0, 0, 8'd1, 1);
        add(1, 0, 0, 0, 0, 0, 8'd1, 1);
        add(1, 0, 0, 0, 0, 0, 8'd1, 1);
        add(0, 0, 0, 0, 0, 1, 8'd1, 1);
        add(0, 0, 0, 0, 0, 1, 8'd1, 1);
        add(0, 1, 0, 0, 0, 0, 8'd0, 0);
        add(0, 0, 0, 0, 0, 0, 8'd0, 0);

        // Test 1: reset state and idle stability.
        #2;
        check("rst_dout", dout_a, 0);
        check("rst_rise", rise_a, 0);
        check("rst_fall", fall_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_cnt", cnt_a, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle_dout", dout_a, 0);
            check("idle_busy", busy_a, 0);
            check("idle_cnt", cnt_a, 0);
        end

        foreach (vecs[i]) begin
            din_a = vecs[i].din;
            clr_a = vecs[i].clr;
            tick();
            check($sformatf("vec%0d_dout", i), dout_a, vecs[i].dout);
            check($sformatf("vec%0d_rise", i), rise_a, vecs[i].rise);
            check($sformatf("vec%0d_fall", i), fall_a, vecs[i].fall);
            check($sformatf("vec%0d_busy", i), busy_a, vecs[i].busy);
            check($sformatf("vec%0d_cnt", i), cnt_a, vecs[i].cnt);
`ifdef GLITCH_FILTER_IRQ_EN
            check($sformatf("vec%0d_irq", i), irq_a, vecs[i].irq);
`endif
        end
        clr_a = 1'b0;

        // Test 4: saturation on the CNT_W=2 instance.
        glitches = 0;
        for (int g = 0; g < 5; g++) begin
            for (int k = 1; k <= 6; k++) begin
                din_b = (k <= 2);
                tick();
                check("sat_dout", dout_b, 0);
                check("sat_pulse", rise_b | fall_b, 0);
            end
            check($sformatf("sat_cnt%0d", g), cnt_b, exp_b[g]);
`ifdef GLITCH_FILTER_IRQ_EN
            check("sat_irq", irq_b, 1);
`endif
            glitches++;
        end
        check("sat_glitches", glitches, 5);

        // Test 6: async reset during qualification, then din=1 at release.
        din_a = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        check("qual_busy", busy_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dout", dout_a, 0);
        check("mid_rst_busy", busy_a, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            tick();
            check($sformatf("rel_dout%0d", k), dout_a, k == lat);
            check($sformatf("rel_rise%0d", k), rise_a, k == lat);
        end
        tick();
        check("rel_rise_end", rise_a, 0);
        check("rel_cnt", cnt_a, 0);
`ifdef GLITCH_FILTER_IRQ_EN
        check("rel_irq", irq_a, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
